sst_engine: RTL and testbench
=============================

# sst_engine

Save-state sequencer that drives the mapper-side SST bus from the other end. On a save it walks SST addresses 0..LAST_ADDR, samples each register byte from `sst_di` and writes it to an external state buffer. On a restore it reads the buffer and replays the bytes into the mapper with `sst_we_reg` strobes, paced to the mapper's falling `cpu_m2` edge. It sits between the system save-state controller/buffer RAM and the mapper's `SSTBus`.

## Interface
- `LAST_ADDR`, default 127: highest SST address walked; this address holds the map index and is read-only.
- `RD_SETTLE`, default 2: clocks held after an address change before `sst_di` is sampled.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `cpu_m2` in 1: mapper clock, asynchronous to `clk`; synchronized internally.
- `start` in 1: one-clock request; ignored while `busy`.
- `dir` in 1: 0 = save, 1 = restore; sampled with `start`.
- `abort` in 1: cancel the operation in progress.
- `map_idx` in 8: current mapper index, used for the restore check.
- `sst_act` out 1: SST bus active.
- `sst_addr` out 8: SST register address.
- `sst_dato` out 8: restore data driven to the mapper.
- `sst_we_reg` out 1: mapper register write strobe.
- `sst_di` in 8: mapper readback for the current `sst_addr`.
- `buf_req` out 1: buffer access request.
- `buf_we` out 1: buffer access direction, 1 = write.
- `buf_addr` out 8: buffer address.
- `buf_dout` out 8: buffer write data.
- `buf_ack` in 1: buffer access complete.
- `buf_din` in 8: buffer read data.
- `busy` out 1: operation in progress.
- `done` out 1: one-clock pulse on successful completion.
- `err` out 1: sticky restore-mismatch flag.

## Operation
- **Reset values**: all outputs 0; state IDLE; address counter 0.
- **States**: IDLE, CHK_RD, CHK_CMP, SETTLE, BUF_WR, BUF_RD, SST_WR, NEXT, DONE, ERR.
- **IDLE**:
  - `start` & `dir`=0 -> SETTLE with counter 0.
  - `start` & `dir`=1 -> CHK_RD.
  - `err` clears on any accepted `start`.
- **`sst_act`**: 1 in every state except IDLE.
- **`sst_addr`**: always equals the counter.
- **Save path**:
  - SETTLE: wait `RD_SETTLE` clocks -> BUF_WR, with `buf_dout` = `sst_di` latched and `buf_addr` = counter.
  - BUF_WR -> NEXT on `buf_ack`.
  - NEXT: counter == `LAST_ADDR` -> DONE, else counter+1 -> SETTLE.
  - The save includes address `LAST_ADDR` (the map index).
- **Restore check**:
  - CHK_RD: read the buffer at `LAST_ADDR`.
  - CHK_CMP: compare the read byte with `map_idx`.
  - Mismatch -> ERR. ERR sets `err`, returns to IDLE, no `done`, and no `sst_we_reg` is ever issued.
  - Match -> BUF_RD with counter 0.
- **Restore path**:
  - BUF_RD -> SST_WR on `buf_ack`, latching `buf_din` into `sst_dato`.
  - SST_WR: hold `sst_we_reg`=1 until a synchronized `cpu_m2` falling edge is seen after entry; deassert, then -> NEXT.
  - NEXT: counter == `LAST_ADDR`-1 -> DONE, else counter+1 -> BUF_RD.
  - Address `LAST_ADDR` is never written to the mapper.
- **DONE**: `done` pulses for one clock -> IDLE.
- **Buffer handshake**:
  - `buf_req`, `buf_we`, `buf_addr` and `buf_dout` are held stable from assertion until the clock `buf_ack`=1 is sampled.
  - `buf_req` drops the next clock.
  - `buf_din` is valid only in the `buf_ack` cycle.
  - `buf_ack` while `buf_req`=0 is ignored.
- **Abort**:
  - With `buf_req` low: -> IDLE next clock; `sst_we_reg` and `sst_act` drop; no `done`.
  - With `buf_req` high: the abort is latched and taken on `buf_ack`.
- **Reset mid-operation**: all outputs clear immediately (asynchronous); `sst_we_reg` never glitches high during reset.

## Timing
- **`cpu_m2` synchronizer**: 2 flops plus an edge register.
  - Fall detected = prev 1 & cur 0.
  - Latency 2–3 `clk` after the actual edge.
- **`sst_we_reg` hold**:
  - Minimum: one full `cpu_m2` fall after assertion.
  - An edge that coincides with the entry clock into SST_WR does not count.
  - This guarantees the mapper's negedge latch sees stable `sst_addr`/`sst_dato`.
- **`sst_addr` and `sst_dato`** change only in NEXT or on BUF_RD `buf_ack`, never while `sst_we_reg`=1.
- **Save duration**: (LAST_ADDR+1)·(RD_SETTLE + ack latency + 2) clocks.
- **`busy`**: 1 from the clock after `start` through the DONE/ERR clock.

## Structure
- Shared package `sst_pkg`:
  - State enum.
  - `SST_ADDR_W`=8.
  - Constant `SST_MAP_IDX_ADDR`=127.
- One sub-module, `sync_edge`: 2-flop synchronizer with falling-edge pulse output, reusable for other `cpu_m2` crossings.

## Test plan
- **Save, zero-latency ack**: `sst_di` = addr^8'h5A, map index 8'h55 at 127 -> 128 buffer writes, `buf_dout` = addr^8'h5A for addr 0..126 and 8'h55 at 127; single `done`; `sst_we_reg` never 1.
- **Restore OK**: buffer[127]=`map_idx`=8'h55, buffer[n]=n, `cpu_m2` at `clk`/24 -> 127 `sst_we_reg` pulses, each spanning one `cpu_m2` fall, with `sst_dato`=n at `sst_addr`=n; no write at 127; `done`.
- **Restore mismatch**: buffer[127]=8'h55, `map_idx`=8'h56 -> one buffer read at 127, `err`=1, no `done`, zero `sst_we_reg`.
- **Ack stall with abort**: abort during a 10-clock `buf_ack` delay -> IDLE one clock after ack, `sst_act`=0, no `done`.
- **Reset mid-SST_WR**: assert `rst_n`=0 mid-SST_WR -> `sst_we_reg`, `sst_act` and `busy` 0 asynchronously; after release a new restore completes normally.
- **Ignored start**: `start` pulsed while `busy` -> ignored; `dir` latched from the first `start` unchanged.

Source files
------------

// File: rtl/sst_pkg.sv
// sst_pkg: shared state encoding and SST bus constants for the save-state sequencer
package sst_pkg;
  localparam int SST_ADDR_W = 8;
  localparam logic [SST_ADDR_W-1:0] SST_MAP_IDX_ADDR = 8'd127;
  typedef enum logic [3:0] {
    IDLE, CHK_RD, CHK_CMP, SETTLE, BUF_WR, BUF_RD, SST_WR, NEXT, DONE, ERR
  } sst_state_e;
  function automatic logic is_buf_state(sst_state_e s);
    return s inside {CHK_RD, BUF_WR, BUF_RD};
  endfunction
endpackage

// File: rtl/sst_engine_if.sv
// sst_engine_if: mapper SST register bus plus the state-buffer request/ack handshake
interface sst_engine_if;
  import sst_pkg::*;
  logic                  sst_act;
  logic [SST_ADDR_W-1:0] sst_addr;
  logic [7:0]            sst_dato;
  logic                  sst_we_reg;
  logic [7:0]            sst_di;
  logic                  buf_req;
  logic                  buf_we;
  logic [SST_ADDR_W-1:0] buf_addr;
  logic [7:0]            buf_dout;
  logic                  buf_ack;
  logic [7:0]            buf_din;
  modport master (
    output sst_act, sst_addr, sst_dato, sst_we_reg, buf_req, buf_we, buf_addr, buf_dout,
    input  sst_di, buf_ack, buf_din
  );
  modport slave (
    input  sst_act, sst_addr, sst_dato, sst_we_reg, buf_req, buf_we, buf_addr, buf_dout,
    output sst_di, buf_ack, buf_din
  );
endinterface

// File: rtl/sst_engine_sync_edge.sv
// sync_edge: two-flop synchronizer with an edge register producing a one-clock falling-edge pulse
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic fall
);
  logic s1, s2, prev;
  // shift the asynchronous input through both sync stages and keep the previous synced sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, prev} <= 3'b000;
    else {s1, s2, prev} <= {d, s1, s2};
  assign fall = prev & ~s2;
endmodule

// File: rtl/sst_engine.sv
// sst_engine: walks the mapper SST bus to save state into, or restore it from, a byte buffer
module sst_engine
  import sst_pkg::*;
#(
  parameter int LAST_ADDR = int'(SST_MAP_IDX_ADDR),
  parameter int RD_SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_m2,
  input  logic         start,
  input  logic         dir,
  input  logic         abort,
  input  logic [7:0]   map_idx,
  output logic         busy,
  output logic         done,
  output logic         err,
  sst_engine_if.master bus
);
  localparam logic [SST_ADDR_W-1:0] LAST = SST_ADDR_W'(LAST_ADDR);
  localparam logic [SST_ADDR_W-1:0] LAST_M1 = SST_ADDR_W'(LAST_ADDR - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(RD_SETTLE > 1 ? RD_SETTLE - 1 : 0);
  sst_state_e state, state_nx;
  logic [SST_ADDR_W-1:0] cnt, cnt_nx;
  logic [7:0] tick, chk_q, dout_q, dato_q;
  logic dir_q, abort_q, err_q, we_q, req, ack, abort_any, m2_fall;
  sync_edge u_m2 (.clk(clk), .rst_n(rst_n), .d(cpu_m2), .fall(m2_fall));
  assign req = is_buf_state(state);
  assign ack = req & bus.buf_ack;
  assign abort_any = abort | abort_q;
  // next state and address counter; an abort outside a buffer access exits at once,
  // inside one it waits for the ack so the buffer never sees a half-finished request
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state != IDLE && abort && !req) state_nx = IDLE;
    else
      case (state)
        IDLE:    if (start) begin
                   state_nx = dir ? CHK_RD : SETTLE;
                   cnt_nx = '0;
                 end
        CHK_RD:  if (ack) state_nx = abort_any ? IDLE : CHK_CMP;
        CHK_CMP: begin
                   state_nx = chk_q == map_idx ? BUF_RD : ERR;
                   cnt_nx = '0;
                 end
        SETTLE:  if (tick == SETTLE_LAST) state_nx = BUF_WR;
        BUF_WR:  if (ack) state_nx = abort_any ? IDLE : NEXT;
        BUF_RD:  if (ack) state_nx = abort_any ? IDLE : SST_WR;
        SST_WR:  if (m2_fall && tick >= 8'd2) state_nx = NEXT;
        NEXT:    if (cnt == (dir_q ? LAST_M1 : LAST)) state_nx = DONE;
                 else begin
                   state_nx = dir_q ? BUF_RD : SETTLE;
                   cnt_nx = cnt + 1'b1;
                 end
        default: state_nx = IDLE;
      endcase
  end
  // state register, per-state clock counter and latched data bytes; the write strobe is
  // registered from the next state so it cannot glitch while the state bits settle, and
  // a fall only counts from the third SST_WR clock so the mapper edge behind it is
  // guaranteed to come after the strobe went high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      tick <= '0;
      dir_q <= 1'b0;
      abort_q <= 1'b0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      chk_q <= '0;
      dout_q <= '0;
      dato_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      tick <= state_nx != state ? 8'd0 : tick + {7'd0, tick != 8'hFF};
      we_q <= state_nx == SST_WR;
      abort_q <= req & ~bus.buf_ack & abort_any;
      err_q <= state_nx == ERR ? 1'b1 : (state == IDLE && start) ? 1'b0 : err_q;
      if (state == IDLE && start) dir_q <= dir;
      if (state == CHK_RD && ack) chk_q <= bus.buf_din;
      if (state == SETTLE && state_nx == BUF_WR) dout_q <= bus.sst_di;
      if (state == BUF_RD && ack) dato_q <= bus.buf_din;
    end
  assign bus.sst_act = state != IDLE;
  assign bus.sst_addr = cnt;
  assign bus.sst_dato = dato_q;
  assign bus.sst_we_reg = we_q;
  assign bus.buf_req = req;
  assign bus.buf_we = state == BUF_WR;
  assign bus.buf_addr = state == CHK_RD ? LAST : cnt;
  assign bus.buf_dout = dout_q;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign err = err_q;
endmodule

// File: tb/tb_sst_engine.sv
// tb_sst_engine: directed save/restore scenarios checked against expected bus transaction sequences
module tb_sst_engine;
  logic clk = 0, rst_n = 0, cpu_m2 = 0, start = 0, dir = 0, abort = 0;
  logic [7:0] map_idx = 8'h55, map_val = 8'h55;
  logic busy, done, err;
  int tests = 0, fails = 0, cyc = 0, ack_lat = 0, ack_cnt = 0;
  int n_wr, n_rd, n_pulse, n_done, n_m2, done_cyc, start_cyc, rd_first;
  logic [7:0] buf_mem [256];
  logic [7:0] wr_log [256];
  logic [15:0] exp_wr[$], exp_sst[$];
  logic [16:0] e;
  logic in_pulse = 0, p_req = 0, p_ack = 0, p_we = 0;
  logic [7:0] p_addr, p_dout, pa, pd, last_pulse_addr;

  sst_engine_if bus();
  sst_engine #(.LAST_ADDR(127), .RD_SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2), .start(start), .dir(dir), .abort(abort),
    .map_idx(map_idx), .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #120 cpu_m2 = ~cpu_m2;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // buffer RAM with programmable ack latency and a mapper whose readback is addr^5A, map index at 127
  assign bus.buf_ack = bus.buf_req && (ack_cnt >= ack_lat);
  always @(posedge clk) ack_cnt <= (bus.buf_req && !bus.buf_ack) ? ack_cnt + 1 : 0;
  assign bus.buf_din = buf_mem[bus.buf_addr];
  assign bus.sst_di = bus.sst_addr == 8'd127 ? map_val : bus.sst_addr ^ 8'h5A;
  always @(negedge cpu_m2) if (bus.sst_we_reg) n_m2 = n_m2 + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // compare process: handshake holding, buffer writes and mapper strobes against the expected queues
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse = 0;
      p_req = 0;
    end else begin
      check("act_vs_busy", bus.sst_act, busy);
      if (p_req && !p_ack) begin
        check("req_hold", bus.buf_req, 1);
        check("req_fields_hold", {bus.buf_we, bus.buf_addr, bus.buf_dout}, {p_we, p_addr, p_dout});
      end
      if (bus.buf_req && bus.buf_ack) begin
        if (bus.buf_we) begin
          n_wr++;
          wr_log[bus.buf_addr] = bus.buf_dout;
          e = exp_wr.size() != 0 ? {1'b1, exp_wr.pop_front()} : 17'h0;
          check("buf_wr", {1'b1, bus.buf_addr, bus.buf_dout}, e);
        end else begin
          n_rd++;
          if (n_rd == 1) rd_first = int'(bus.buf_addr);
        end
      end
      {p_req, p_ack, p_we, p_addr, p_dout} = {bus.buf_req, bus.buf_ack, bus.buf_we, bus.buf_addr, bus.buf_dout};
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.sst_we_reg && !in_pulse) begin
        in_pulse = 1;
        pa = bus.sst_addr;
        pd = bus.sst_dato;
      end else if (bus.sst_we_reg) check("we_addr_data_stable", {bus.sst_addr, bus.sst_dato}, {pa, pd});
      else if (in_pulse) begin
        in_pulse = 0;
        n_pulse++;
        last_pulse_addr = pa;
        check("m2_fall_in_pulse", n_m2 != 0, 1);
        e = exp_sst.size() != 0 ? {1'b1, exp_sst.pop_front()} : 17'h0;
        check("sst_wr", {1'b1, pa, pd}, e);
      end
      if (!bus.sst_we_reg) n_m2 = 0;
    end
  end

  task automatic clear();
    exp_wr.delete();
    exp_sst.delete();
    n_wr = 0; n_rd = 0; n_pulse = 0; n_done = 0; rd_first = -1;
  endtask

  task automatic go(input logic d);
    @(negedge clk);
    start = 1; dir = d; start_cyc = cyc + 1;
    @(negedge clk);
    start = 0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic run_save(input int lat, input logic [7:0] mv, input logic poke, input int dur);
    clear();
    ack_lat = lat; map_val = mv;
    for (int a = 0; a < 128; a++) exp_wr.push_back({8'(a), a == 127 ? mv : 8'(a) ^ 8'h5A});
    go(0);
    if (poke) begin
      repeat (100) @(negedge clk);
      start = 1; dir = 1;
      @(negedge clk);
      start = 0; dir = 0;
    end
    wait_idle(2000);
    check("save_writes", n_wr, 128);
    check("save_done", n_done, 1);
    check("save_no_we", n_pulse, 0);
    check("save_no_reads", n_rd, 0);
    check("save_cycles", done_cyc - start_cyc, dur);
    check("save_queue_empty", exp_wr.size(), 0);
  endtask

  task automatic run_restore(input logic [7:0] mi, input int budget);
    clear();
    ack_lat = 2; map_idx = mi;
    if (mi == buf_mem[127]) for (int n = 0; n < 127; n++) exp_sst.push_back({8'(n), buf_mem[n]});
    go(1);
    check("err_cleared_on_start", err, 0);
    wait_idle(budget);
  endtask

  initial begin
    int k;
    for (int n = 0; n < 256; n++) buf_mem[n] = n < 127 ? 8'(n) : 8'h00;
    buf_mem[127] = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus.sst_act, bus.sst_we_reg, bus.buf_req, bus.buf_we, busy, done, err}, 0);
    check("rst_addr", {bus.sst_addr, bus.buf_addr}, 0);
    check("rst_data", {bus.sst_dato, bus.buf_dout}, 0);
    rst_n = 1;

    run_save(0, 8'h55, 0, 512);
    check("save_byte0", wr_log[0], 8'h5A);
    check("save_byte126", wr_log[126], 8'h24);
    check("save_byte127", wr_log[127], 8'h55);

    run_restore(8'h56, 200);
    check("mismatch_err", err, 1);
    check("mismatch_no_done", n_done, 0);
    check("mismatch_no_we", n_pulse, 0);
    check("mismatch_reads", n_rd, 1);
    check("mismatch_read_addr", rd_first, 127);

    run_restore(8'h55, 10000);
    check("restore_err", err, 0);
    check("restore_done", n_done, 1);
    check("restore_pulses", n_pulse, 127);
    check("restore_last_addr", last_pulse_addr, 8'd126);
    check("restore_reads", n_rd, 128);
    check("restore_first_read", rd_first, 127);
    check("restore_no_writes", n_wr, 0);
    check("restore_queue_empty", exp_sst.size(), 0);

    run_save(1, 8'h33, 1, 640);

    clear();
    ack_lat = 10; map_val = 8'h55;
    exp_wr.push_back({8'd0, 8'h5A});
    go(0);
    k = 0;
    while (!bus.buf_req && k < 20) begin @(negedge clk); k++; end
    check("abort_req_seen", bus.buf_req, 1);
    repeat (3) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    k = 0;
    while (!(bus.buf_req && bus.buf_ack) && k < 30) begin @(negedge clk); k++; end
    check("abort_ack_seen", bus.buf_ack, 1);
    check("abort_waits_for_ack", busy, 1);
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_act", bus.sst_act, 0);
    repeat (5) @(negedge clk);
    check("abort_no_done", n_done, 0);
    check("abort_writes", n_wr, 1);

    clear();
    ack_lat = 2; map_idx = 8'h55;
    go(1);
    k = 0;
    while (!bus.sst_we_reg && k < 100) begin @(negedge clk); k++; end
    check("rst_test_we_seen", bus.sst_we_reg, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_we", bus.sst_we_reg, 0);
    check("async_rst_act", bus.sst_act, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_restore(8'h55, 10000);
    check("post_rst_done", n_done, 1);
    check("post_rst_pulses", n_pulse, 127);
    check("post_rst_queue_empty", exp_sst.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
